// File: rtl/operand_fetch_sequencer.sv
// Operand fetch sequencer: opcode byte plus up to two operand bytes.
// Define FETCH_TIMEOUT_EN to abort a stalled operand fetch after 15 idle cycles.
module operand_fetch_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [7:0] opcode,
    output logic [7:0] byte_out,
    output logic       set_low,
    output logic       set_high,
    output logic [1:0] instr_len,
    output logic       instr_valid,
    input  logic       instr_ack,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_LO,
        FETCH_HI,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] len_d;

    function automatic logic [1:0] decode_len(input logic [7:0] op);
        case (op)
            8'h01, 8'h11, 8'h21, 8'h31,
            8'h22, 8'h2A, 8'h32, 8'h3A,
            8'hC3, 8'hCD, 8'hC2, 8'hCA,
            8'hD2, 8'hDA, 8'hE2, 8'hEA,
            8'hF2, 8'hFA, 8'hC4, 8'hCC,
            8'hD4, 8'hDC, 8'hE4, 8'hEC,
            8'hF4, 8'hFC:
                decode_len = 2'd3;
            8'h06, 8'h0E, 8'h16, 8'h1E,
            8'h26, 8'h2E, 8'h36, 8'h3E,
            8'hC6, 8'hCE, 8'hD6, 8'hDE,
            8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hD3, 8'hDB:
                decode_len = 2'd2;
            default:
                decode_len = 2'd1;
        endcase
    endfunction

    assign len_d       = decode_len(mem_data);
    assign byte_ready  = (state != DONE);
    assign instr_valid = (state == DONE);

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] idle_cnt;
    logic       fetching;
    logic       tmo_hit;

    assign fetching = (state == FETCH_LO) || (state == FETCH_HI);
    // Fires on the 15th consecutive idle cycle (count 14 -> 15).
    assign tmo_hit  = fetching && !byte_valid && (idle_cnt == 4'd14);

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt    <= 4'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (!fetching || byte_valid || tmo_hit)
                idle_cnt <= 4'd0;
            else
                idle_cnt <= idle_cnt + 4'd1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH_OP;
            opcode    <= 8'h00;
            byte_out  <= 8'h00;
            set_low   <= 1'b0;
            set_high  <= 1'b0;
            instr_len <= 2'd1;
        end else begin
            set_low  <= 1'b0;
            set_high <= 1'b0;
            unique case (state)
                FETCH_OP: begin
                    if (byte_valid) begin
                        opcode    <= mem_data;
                        instr_len <= len_d;
                        state     <= (len_d == 2'd1) ? DONE : FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (byte_valid) begin
                        byte_out <= mem_data;
                        set_low  <= 1'b1;
                        state    <= (instr_len == 2'd3) ? FETCH_HI : DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state <= FETCH_OP;
                    end
`endif
                end
                FETCH_HI: begin
                    if (byte_valid) begin
                        byte_out <= mem_data;
                        set_high <= 1'b1;
                        state    <= DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state <= FETCH_OP;
                    end
`endif
                end
                DONE: begin
                    if (instr_ack)
                        state <= FETCH_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Scoreboard bench for operand_fetch_sequencer: directed byte streams,
// expected strobes/instructions queued by the driver, checked by a monitor.
module tb_operand_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_data;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] opcode;
    logic [7:0] byte_out;
    logic       set_low;
    logic       set_high;
    logic [1:0] instr_len;
    logic       instr_valid;
    logic       instr_ack;
    logic       timeout_err;

    operand_fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .mem_data    (mem_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .opcode      (opcode),
        .byte_out    (byte_out),
        .set_low     (set_low),
        .set_high    (set_high),
        .instr_len   (instr_len),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [1:0] K_LO  = 2'd0;
    localparam logic [1:0] K_HI  = 2'd1;
    localparam logic [1:0] K_INS = 2'd2;
    localparam logic [1:0] K_TMO = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic [1:0] len;
        int         cyc;
    } ev_t;

    ev_t         q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        iv_q     = 1'b0;
    logic [15:0] pair     = 16'h0000;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] d,
                        input logic [1:0] l, input int c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.len  = l;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [7:0] d,
                             input logic [1:0] l);
        ev_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d data %0h cycle %0d, none expected",
                     k, d, cyc);
        end else begin
            e = q.pop_front();
            chk("ev_kind", 32'(k), 32'(e.kind));
            chk("ev_data", 32'(d), 32'(e.data));
            chk("ev_len", 32'(l), 32'(e.len));
            chk("ev_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: observes strobes, instruction arrival and timeout pulses.
    always @(negedge clk) begin
        if (set_low || set_high)
            chk("strobe_exclusive", 32'(set_low && set_high), 32'd0);
        if (set_low) begin
            pair[7:0] = byte_out;
            expect_ev(K_LO, byte_out, 2'd0);
        end
        if (set_high) begin
            pair[15:8] = byte_out;
            expect_ev(K_HI, byte_out, 2'd0);
        end
        if (instr_valid && !iv_q)
            expect_ev(K_INS, opcode, instr_len);
        if (timeout_err)
            expect_ev(K_TMO, 8'h00, 2'd0);
        iv_q = instr_valid;
    end

    // Present a byte from a negedge; returns the edge number it transfers on.
    task automatic send(input logic [7:0] b, output int edge_n);
        int w = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        mem_data   = b;
        while (!byte_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!byte_ready)
            chk("send_ready_timeout", 32'(byte_ready), 32'd1);
        edge_n = cyc + 1;
    endtask

    task automatic idle();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_ack();
        int w = 0;
        @(negedge clk);
        byte_valid = 1'b0;
        while (!instr_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("ack_wait_valid", 32'(instr_valid), 32'd1);
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        chk("ack_ready_back", 32'(byte_ready), 32'd1);
        chk("ack_valid_drop", 32'(instr_valid), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_opcode"}, 32'(opcode), 32'h00);
        chk({tag, "_byte_out"}, 32'(byte_out), 32'h00);
        chk({tag, "_set_low"}, 32'(set_low), 32'd0);
        chk({tag, "_set_high"}, 32'(set_high), 32'd0);
        chk({tag, "_instr_len"}, 32'(instr_len), 32'd1);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
    endtask

    logic [7:0] tbl_op[6]  = '{8'h01, 8'h76, 8'hFE, 8'hDB, 8'hFC, 8'hC9};
    logic [1:0] tbl_len[6] = '{2'd3, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1};

    initial begin
        int e;
        rst        = 1'b1;
        byte_valid = 1'b0;
        mem_data   = 8'h00;
        instr_ack  = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;

        // Single-byte opcode
        send(8'h00, e);
        push(K_INS, 8'h00, 2'd1, e);
        do_ack();

        // Two-byte: one low strobe with the operand
        send(8'h3E, e);
        send(8'h5A, e);
        push(K_LO, 8'h5A, 2'd0, e);
        push(K_INS, 8'h3E, 2'd2, e);
        do_ack();

        // Three-byte back-to-back
        send(8'hC3, e);
        send(8'h34, e);
        push(K_LO, 8'h34, 2'd0, e);
        send(8'h12, e);
        push(K_HI, 8'h12, 2'd0, e);
        push(K_INS, 8'hC3, 2'd3, e);
        do_ack();
        chk("reg_pair", 32'(pair), 32'h1234);

        // Ack withheld: DONE holds, next opcode waits
        send(8'h06, e);
        send(8'h9C, e);
        push(K_LO, 8'h9C, 2'd0, e);
        push(K_INS, 8'h06, 2'd2, e);
        repeat (5) begin
            @(negedge clk);
            byte_valid = 1'b1;
            mem_data   = 8'h00;
            chk("hold_ready", 32'(byte_ready), 32'd0);
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_opcode", 32'(opcode), 32'h06);
            chk("hold_len", 32'(instr_len), 32'd2);
            chk("hold_byte_out", 32'(byte_out), 32'h9C);
        end
        @(negedge clk);
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        chk("after_ack_ready", 32'(byte_ready), 32'd1);
        push(K_INS, 8'h00, 2'd1, cyc + 1);
        do_ack();

        // Reset mid-instruction
        send(8'hCD, e);
        send(8'h78, e);
        push(K_LO, 8'h78, 2'd0, e);
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b1;
        mem_data   = 8'h56;
        instr_ack  = 1'b1;
        @(negedge clk);
        chk_reset("rst1");
        rst        = 1'b0;
        byte_valid = 1'b0;
        instr_ack  = 1'b0;
        send(8'h00, e);
        push(K_INS, 8'h00, 2'd1, e);
        do_ack();

`ifdef FETCH_TIMEOUT_EN
        send(8'h21, e);
        push(K_TMO, 8'h00, 2'd0, e + 15);
        repeat (15) idle();
        send(8'h00, e);
        push(K_INS, 8'h00, 2'd1, e);
        do_ack();
`else
        send(8'h21, e);
        repeat (20) idle();
        chk("stall_ready", 32'(byte_ready), 32'd1);
        chk("stall_valid", 32'(instr_valid), 32'd0);
        send(8'h34, e);
        push(K_LO, 8'h34, 2'd0, e);
        send(8'h12, e);
        push(K_HI, 8'h12, 2'd0, e);
        push(K_INS, 8'h21, 2'd3, e);
        do_ack();
`endif

        // Decode table sweep
        for (int i = 0; i < 6; i++) begin
            send(tbl_op[i], e);
            if (tbl_len[i] == 2'd1) begin
                push(K_INS, tbl_op[i], 2'd1, e);
            end else begin
                send(8'hA0 + 8'(i), e);
                push(K_LO, 8'hA0 + 8'(i), 2'd0, e);
                if (tbl_len[i] == 2'd3) begin
                    send(8'hB0 + 8'(i), e);
                    push(K_HI, 8'hB0 + 8'(i), 2'd0, e);
                end
                push(K_INS, tbl_op[i], tbl_len[i], e);
            end
            do_ack();
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/operand_fetch_sequencer.md
OPERAND_FETCH_SEQUENCER -- requirements
Module: operand_fetch_sequencer

Interface
REQ-001 SHALL provide clk, input, 1, clock; all state changes on posedge clk.
REQ-002 SHALL provide rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL provide mem_data, input, 8, byte from program memory.
REQ-004 SHALL provide byte_valid, input, 1, mem_data valid this cycle.
REQ-005 SHALL provide byte_ready, output, 1, sequencer accepts a byte; a transfer occurs when byte_valid && byte_ready.
REQ-006 SHALL provide opcode, output, 8, opcode of the current instruction.
REQ-007 SHALL provide byte_out, output, 8, operand byte to the 16-bit register pair input.
REQ-008 SHALL provide set_low and set_high, outputs, 1 each, half-select strobes to the 16-bit register pair.
REQ-009 SHALL provide instr_len, output, 2, instruction length of 1, 2 or 3.
REQ-010 SHALL provide instr_valid, output, 1, complete instruction available.
REQ-011 SHALL provide instr_ack, input, 1, consumer accepts the instruction.
REQ-012 SHALL provide timeout_err, output, 1, one-cycle pulse on operand timeout.

Function
REQ-013 SHALL implement the states FETCH_OP, FETCH_LO, FETCH_HI and DONE.
REQ-014 SHALL drive byte_ready=1 in FETCH_OP, FETCH_LO and FETCH_HI, and byte_ready=0 in DONE.
REQ-015 SHALL, on a FETCH_OP transfer, register opcode and decode its length.
- Length 3: 01, 11, 21, 31, 22, 2A, 32, 3A, C3, CD, C2, CA, D2, DA, E2, EA, F2, FA, C4, CC, D4, DC, E4, EC, F4, FC.
- Length 2: 06, 0E, 16, 1E, 26, 2E, 36, 3E, C6, CE, D6, DE, E6, EE, F6, FE, D3, DB.
- Length 1: all other opcodes.
REQ-016 SHALL transition from FETCH_OP to DONE for length 1, and to FETCH_LO for lengths 2 and 3.
REQ-017 SHALL, on a FETCH_LO transfer, go to FETCH_HI for length 3 and to DONE for length 2.
REQ-018 SHALL, on a FETCH_HI transfer, go to DONE.
REQ-019 SHALL, in the cycle after a FETCH_LO transfer, drive byte_out=captured byte with set_low=1 and set_high=0 for exactly one cycle.
REQ-020 SHALL, in the cycle after a FETCH_HI transfer, drive byte_out=captured byte with set_high=1 and set_low=0 for exactly one cycle.
REQ-021 SHALL never assert set_low and set_high in the same cycle.
REQ-022 SHALL hold set_low and set_high at 0 at all other times.
REQ-023 SHALL keep byte_out stable when no strobe is active.
REQ-024 SHALL, in DONE, assert instr_valid with opcode and instr_len held stable until instr_ack=1.
REQ-025 SHALL, on instr_ack in DONE, return to FETCH_OP in the next cycle.
REQ-026 SHALL ignore instr_ack outside DONE.
REQ-027 SHALL leave state, opcode and strobes unchanged on any cycle without a transfer in a FETCH state.
REQ-028 SHALL give instr_valid a latency of exactly 1 cycle after the final-byte transfer.
REQ-029 SHALL assert instr_valid in the same cycle as the final strobe when length is 2 or 3.
REQ-030 SHALL sustain one byte per cycle under back-to-back byte_valid.

Reset
REQ-031 SHALL, with rst=1 at a clock edge, enter FETCH_OP and set opcode=00, byte_out=00, set_low=0, set_high=0, instr_len=1, instr_valid=0 and timeout_err=0.
REQ-032 SHALL, on rst mid-instruction, abandon the partial instruction and suppress any pending strobe.
REQ-033 SHALL give rst priority over byte_valid and instr_ack.

Configuration
REQ-034 SHALL, when FETCH_TIMEOUT_EN is defined, count idle cycles in FETCH_LO and FETCH_HI with a 4-bit counter cleared on each transfer.
REQ-035 SHALL, when FETCH_TIMEOUT_EN is defined and the count reaches 15, return to FETCH_OP, pulse timeout_err for one cycle and emit no strobe for the missing byte.
REQ-036 SHALL, when FETCH_TIMEOUT_EN is undefined, wait indefinitely in FETCH_LO and FETCH_HI and tie timeout_err to 0.

Verification
REQ-037 SHALL cover: stream 00 with ack -> instr_len=1, instr_valid 1 cycle after transfer, no strobes.
REQ-038 SHALL cover: stream 3E, 5A -> one set_low pulse with byte_out=5A, instr_len=2, set_high never asserted.
REQ-039 SHALL cover: stream C3, 34, 12 back-to-back -> set_low with 34, then set_high with 12 on the next cycle, instr_len=3; register pair reads 1234.
REQ-040 SHALL cover: instr_ack held 0 for 5 cycles in DONE -> byte_ready=0 and opcode/instr_len stable; the next opcode is accepted only after ack.
REQ-041 SHALL cover: rst asserted after CD, 78 -> no set_high, all outputs at reset values, and a subsequent 00 decodes cleanly.
REQ-042 SHALL cover, with FETCH_TIMEOUT_EN defined: 21 then 15 idle cycles -> timeout_err pulse, return to FETCH_OP, no strobe.
